// File: rtl/lcd_timing_pkg.sv
// Panel timing defaults for the LTM LCD stream, shared with the timing
// controller, plus the lock FSM state type used by the capture block.
package lcd_timing_pkg;

    // Active video and total frame geometry
    localparam int LCD_H_LINE      = 1056;  // pixel clocks, HD fall to HD fall
    localparam int LCD_V_LINE      = 525;   // lines, VD fall to VD fall
    localparam int LCD_H_ACTIVE    = 800;   // DEN-high clocks per active line
    localparam int LCD_V_ACTIVE    = 480;   // active lines per frame
    localparam int LCD_LOCK_FRAMES = 2;     // clean frames needed to lock

    // Blanking / porch constants (sync + back porch, front porch)
    localparam int LCD_H_BACK      = 216;   // HD fall to first DEN clock
    localparam int LCD_H_FRONT     = 40;    // last DEN clock to next HD fall
    localparam int LCD_V_BACK      = 35;    // VD fall to first active line
    localparam int LCD_V_FRONT     = 10;    // last active line to next VD fall

    typedef enum logic [1:0] {
        UNLOCK  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } cap_state_e;

endpackage

// File: rtl/lcd_sync_edge_detect.sv
// Stage-1 input registers for the LCD stream and falling-edge pulses of
// HD, VD and DEN derived from the registered value against its history.
module lcd_sync_edge_detect
    import lcd_timing_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        hd,
    input  logic        vd,
    input  logic        den,
    input  logic [23:0] rgb,
    output logic        den_s1,
    output logic [23:0] rgb_s1,
    output logic        hd_fall,
    output logic        vd_fall,
    output logic        den_fall
);

    logic        hd_s1_q,   hd_s1_d;
    logic        vd_s1_q,   vd_s1_d;
    logic        den_s1_q,  den_s1_d;
    logic [23:0] rgb_s1_q,  rgb_s1_d;
    logic        hd_prev_q, hd_prev_d;
    logic        vd_prev_q, vd_prev_d;
    logic        den_prev_q, den_prev_d;

    // Next values: sample pins, and keep one cycle of stage-1 history
    always_comb begin
        hd_s1_d    = hd;
        vd_s1_d    = vd;
        den_s1_d   = den;
        rgb_s1_d   = rgb;
        hd_prev_d  = hd_s1_q;
        vd_prev_d  = vd_s1_q;
        den_prev_d = den_s1_q;
    end

    // Syncs idle high and DEN idles low so reset never fakes an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            hd_s1_q    <= 1'b1;
            vd_s1_q    <= 1'b1;
            den_s1_q   <= 1'b0;
            rgb_s1_q   <= 24'd0;
            hd_prev_q  <= 1'b1;
            vd_prev_q  <= 1'b1;
            den_prev_q <= 1'b0;
        end else begin
            hd_s1_q    <= hd_s1_d;
            vd_s1_q    <= vd_s1_d;
            den_s1_q   <= den_s1_d;
            rgb_s1_q   <= rgb_s1_d;
            hd_prev_q  <= hd_prev_d;
            vd_prev_q  <= vd_prev_d;
            den_prev_q <= den_prev_d;
        end
    end

    assign den_s1   = den_s1_q;
    assign rgb_s1   = rgb_s1_q;
    assign hd_fall  = hd_prev_q  & ~hd_s1_q;
    assign vd_fall  = vd_prev_q  & ~vd_s1_q;
    assign den_fall = den_prev_q & ~den_s1_q;

endmodule

// File: rtl/lcd_stream_capture.sv
// Receive side of the LTM LCD interface: recovers active-pixel coordinates,
// checks line/frame timing, tracks lock and emits registered pixel writes
// for the SDRAM frame-buffer writer. Pins to outputs is two clocks.
module lcd_stream_capture
    import lcd_timing_pkg::*;
#(
    parameter int H_LINE      = LCD_H_LINE,
    parameter int V_LINE      = LCD_V_LINE,
    parameter int H_ACTIVE    = LCD_H_ACTIVE,
    parameter int V_ACTIVE    = LCD_V_ACTIVE,
    parameter int LOCK_FRAMES = LCD_LOCK_FRAMES
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iHD,
    input  logic       iVD,
    input  logic       iDEN,
    input  logic [7:0] iLCD_R,
    input  logic [7:0] iLCD_G,
    input  logic [7:0] iLCD_B,
    output logic       oWRITE_SDRAM_EN,
    output logic [7:0] oRed,
    output logic [7:0] oGreen,
    output logic [7:0] oBlue,
    output logic [9:0] oX,
    output logic [8:0] oY,
    output logic       oFRAME_START,
    output logic       oLOCKED,
    output logic       oERR
);

    localparam logic [10:0] H_LAST    = 11'(H_LINE - 1);
    localparam logic [10:0] V_TOTAL   = 11'(V_LINE);
    localparam logic [9:0]  PX_TOTAL  = 10'(H_ACTIVE);
    localparam logic [8:0]  ACT_ROWS  = 9'(V_ACTIVE);
    localparam logic [3:0]  GOOD_LOCK = 4'(LOCK_FRAMES);

    // Stage 1
    logic        hd_fall, vd_fall, den_fall, den_s1;
    logic [23:0] rgb_s1;

    lcd_sync_edge_detect u_edge (
        .clk      (iCLK),
        .rst      (iRST),
        .hd       (iHD),
        .vd       (iVD),
        .den      (iDEN),
        .rgb      ({iLCD_R, iLCD_G, iLCD_B}),
        .den_s1   (den_s1),
        .rgb_s1   (rgb_s1),
        .hd_fall  (hd_fall),
        .vd_fall  (vd_fall),
        .den_fall (den_fall)
    );

    // Timing counters and lock state
    logic [10:0] h_cnt_q,    h_cnt_d;
    logic [9:0]  line_cnt_q, line_cnt_d;
    logic [9:0]  px_cnt_q,   px_cnt_d;
    logic [8:0]  act_cnt_q,  act_cnt_d;
    logic        h_armed_q,  h_armed_d;
    cap_state_e  state_q,    state_d;
    logic [3:0]  good_q,     good_d;

    logic line_err, frame_err, den_err, err;

    // Stage 2 output registers
    logic        wr_en_q, wr_en_d;
    logic [23:0] rgb_q,   rgb_d;
    logic [9:0]  x_q,     x_d;
    logic [8:0]  y_q,     y_d;
    logic        fs_q,    fs_d;
    logic        locked_q, locked_d;
    logic        err_q,   err_d;

    // Timing checks against the counters as they stand before this edge.
    // The line check needs one hd_fall of history to mean anything.
    always_comb begin
        line_err  = hd_fall && h_armed_q && (h_cnt_q != H_LAST);
        frame_err = vd_fall &&
                    ((({1'b0, line_cnt_q} + {10'd0, hd_fall}) != V_TOTAL) ||
                     (act_cnt_q != ACT_ROWS));
        den_err   = den_fall && (px_cnt_q != PX_TOTAL);
        err       = line_err || frame_err || den_err;
    end

    // Counter next-state; every counter saturates so overflow can't alias
    always_comb begin
        h_cnt_d    = h_cnt_q;
        line_cnt_d = line_cnt_q;
        px_cnt_d   = px_cnt_q;
        act_cnt_d  = act_cnt_q;

        if (hd_fall)                h_cnt_d = 11'd0;
        else if (h_cnt_q != '1)     h_cnt_d = h_cnt_q + 11'd1;

        if (vd_fall)                       line_cnt_d = 10'd0;
        else if (hd_fall && line_cnt_q != '1) line_cnt_d = line_cnt_q + 10'd1;

        if (hd_fall)                       px_cnt_d = 10'd0;
        else if (den_s1 && px_cnt_q != '1) px_cnt_d = px_cnt_q + 10'd1;

        if (vd_fall)                          act_cnt_d = 9'd0;
        else if (den_fall && act_cnt_q != '1) act_cnt_d = act_cnt_q + 9'd1;
    end

    // Lock FSM: errors are ignored until the first VD fall starts acquisition
    always_comb begin
        state_d   = state_q;
        good_d    = good_q;
        h_armed_d = h_armed_q | hd_fall;
        case (state_q)
            UNLOCK: begin
                if (vd_fall) begin
                    state_d = ACQUIRE;
                    good_d  = 4'd0;
                end
            end
            ACQUIRE: begin
                // An error on the same edge as VD fall still drops lock
                if (err) begin
                    state_d = UNLOCK;
                    good_d  = 4'd0;
                end else if (vd_fall) begin
                    good_d = good_q + 4'd1;
                    if (good_q + 4'd1 == GOOD_LOCK) state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (err) state_d = UNLOCK;
            end
            default: state_d = UNLOCK;
        endcase
        // Losing lock restarts line-length history from scratch
        if (err && state_q != UNLOCK) h_armed_d = 1'b0;
    end

    // Output stage: pixel data and coordinates only move with the strobe
    always_comb begin
        wr_en_d  = den_s1 && (state_q == LOCKED) && !err;
        rgb_d    = rgb_q;
        x_d      = x_q;
        y_d      = y_q;
        if (wr_en_d) begin
            rgb_d = rgb_s1;
            x_d   = px_cnt_q;
            y_d   = act_cnt_q;
        end
        fs_d     = vd_fall && (state_q == LOCKED) && !frame_err;
        locked_d = (state_d == LOCKED);
        err_d    = err && (state_q != UNLOCK);
    end

    // Counter and FSM state registers
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            h_cnt_q    <= 11'd0;
            line_cnt_q <= 10'd0;
            px_cnt_q   <= 10'd0;
            act_cnt_q  <= 9'd0;
            h_armed_q  <= 1'b0;
            state_q    <= UNLOCK;
            good_q     <= 4'd0;
        end else begin
            h_cnt_q    <= h_cnt_d;
            line_cnt_q <= line_cnt_d;
            px_cnt_q   <= px_cnt_d;
            act_cnt_q  <= act_cnt_d;
            h_armed_q  <= h_armed_d;
            state_q    <= state_d;
            good_q     <= good_d;
        end
    end

    // Stage-2 output registers
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            wr_en_q  <= 1'b0;
            rgb_q    <= 24'd0;
            x_q      <= 10'd0;
            y_q      <= 9'd0;
            fs_q     <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wr_en_q  <= wr_en_d;
            rgb_q    <= rgb_d;
            x_q      <= x_d;
            y_q      <= y_d;
            fs_q     <= fs_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

    assign oWRITE_SDRAM_EN = wr_en_q;
    assign oRed            = rgb_q[23:16];
    assign oGreen          = rgb_q[15:8];
    assign oBlue           = rgb_q[7:0];
    assign oX              = x_q;
    assign oY              = y_q;
    assign oFRAME_START    = fs_q;
    assign oLOCKED         = locked_q;
    assign oERR            = err_q;

endmodule

// File: tb/tb_lcd_stream_capture.sv
// Scoreboard bench for lcd_stream_capture on a scaled-down panel geometry.
// A frame generator drives directed frames and queues the expected output
// events with their cycle stamps; a negedge monitor pops and compares.
module tb_lcd_stream_capture;

    localparam int TH = 24;  // clocks per line
    localparam int TV = 12;  // lines per frame
    localparam int TA = 12;  // active pixels per line
    localparam int VA = 6;   // active lines
    localparam int HB = 8;   // HD fall to first DEN
    localparam int VB = 3;   // first active line

    localparam int EV_ERR = 0, EV_LFALL = 1, EV_LRISE = 2, EV_FS = 3, EV_STB = 4;
    // vd_ev bit masks
    localparam int B_ERR = 1, B_LFALL = 2, B_LRISE = 4, B_FS = 8;

    typedef struct {
        int          kind;
        int          cyc;
        int          x;
        int          y;
        logic [23:0] rgb;
    } ev_t;

    logic       iCLK = 1'b0;
    logic       iRST, iHD, iVD, iDEN;
    logic [7:0] iLCD_R, iLCD_G, iLCD_B;
    logic       oWRITE_SDRAM_EN, oFRAME_START, oLOCKED, oERR;
    logic [7:0] oRed, oGreen, oBlue;
    logic [9:0] oX;
    logic [8:0] oY;

    int  cyc = 0;
    int  errors = 0;
    int  checks = 0;
    int  strobes = 0;
    bit  prev_locked = 1'b0;
    ev_t exp_q[$];

    lcd_stream_capture #(
        .H_LINE(TH), .V_LINE(TV), .H_ACTIVE(TA), .V_ACTIVE(VA), .LOCK_FRAMES(2)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iHD(iHD), .iVD(iVD), .iDEN(iDEN),
        .iLCD_R(iLCD_R), .iLCD_G(iLCD_G), .iLCD_B(iLCD_B),
        .oWRITE_SDRAM_EN(oWRITE_SDRAM_EN), .oRed(oRed), .oGreen(oGreen),
        .oBlue(oBlue), .oX(oX), .oY(oY), .oFRAME_START(oFRAME_START),
        .oLOCKED(oLOCKED), .oERR(oERR)
    );

    always #5 iCLK = ~iCLK;
    always @(posedge iCLK) cyc <= cyc + 1;

    function automatic logic [23:0] pix(input int x, input int y);
        if (x == 7 && y == 2) return 24'hA55A3C;
        return {8'(x * 5 + 1), 8'(y * 17 + 3), 8'(x ^ (y << 4))};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_ev(input int kind, input int c, input int x, input int y,
                           input logic [23:0] rgb);
        ev_t e;
        e.kind = kind; e.cyc = c; e.x = x; e.y = y; e.rgb = rgb;
        exp_q.push_back(e);
    endtask

    task automatic push_flags(input int bits, input int c);
        for (int k = 0; k < 4; k++)
            if (bits[k]) push_ev(k, c, 0, 0, 24'd0);
    endtask

    task automatic observe(input int kind);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event: unexpected kind=%0d at cycle %0d, queue empty", kind, cyc);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.cyc != cyc ||
            (kind == EV_STB && (e.x != int'(oX) || e.y != int'(oY) ||
                                e.rgb != {oRed, oGreen, oBlue}))) begin
            errors++;
            $display("FAIL event: got kind=%0d cyc=%0d x=%0d y=%0d rgb=%06h, expected kind=%0d cyc=%0d x=%0d y=%0d rgb=%06h",
                     kind, cyc, oX, oY, {oRed, oGreen, oBlue},
                     e.kind, e.cyc, e.x, e.y, e.rgb);
        end
    endtask

    // Monitor: compare every observed output event against the queue
    initial begin
        forever begin
            @(negedge iCLK);
            if (oERR) observe(EV_ERR);
            if (prev_locked && !oLOCKED) observe(EV_LFALL);
            if (!prev_locked && oLOCKED) observe(EV_LRISE);
            if (oFRAME_START) observe(EV_FS);
            if (oWRITE_SDRAM_EN) begin
                observe(EV_STB);
                strobes++;
            end
            prev_locked = oLOCKED;
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_en"},  int'(oWRITE_SDRAM_EN), 0);
        chk({tag, "_red"},    int'(oRed), 0);
        chk({tag, "_green"},  int'(oGreen), 0);
        chk({tag, "_blue"},   int'(oBlue), 0);
        chk({tag, "_x"},      int'(oX), 0);
        chk({tag, "_y"},      int'(oY), 0);
        chk({tag, "_fs"},     int'(oFRAME_START), 0);
        chk({tag, "_locked"}, int'(oLOCKED), 0);
        chk({tag, "_err"},    int'(oERR), 0);
    endtask

    // One frame of stimulus. vd_ev: hand-derived events at this frame's VD
    // fall; cap: whether the DUT is expected locked over the active area.
    // Long/short-line errors and the mid-frame reset all happen while locked.
    task automatic run_frame(input int nlines, input int long_line, input int short_line,
                             input int rst_line, input int vd_ev, input int cap_in);
        int  cap, len, n;
        bit  den, rst_chk;
        cap = cap_in;
        rst_chk = 1'b0;
        for (int l = 0; l < nlines; l++) begin
            len = TH + ((l == long_line) ? 1 : 0);
            for (int h = 0; h < len; h++) begin
                den = (l >= VB) && (l < VB + VA) && (h >= HB) &&
                      (h < HB + TA - ((l == short_line) ? 1 : 0));
                @(negedge iCLK);
                if (rst_chk) begin
                    chk_all_zero("midreset");
                    rst_chk = 1'b0;
                end
                n = cyc;
                iHD  = (h != 0);
                iVD  = !(l == 0 && h >= 1);
                iDEN = den;
                {iLCD_R, iLCD_G, iLCD_B} = den ? pix(h - HB, l - VB) : 24'h000000;
                iRST = (l == rst_line && h == 5);
                if (l == 0 && h == 1) push_flags(vd_ev, n + 2);
                if (long_line >= 0 && l == long_line + 1 && h == 0) begin
                    push_flags(B_ERR | B_LFALL, n + 2);
                    cap = 0;
                end
                if (l == short_line && h == HB + TA - 1) begin
                    push_flags(B_ERR | B_LFALL, n + 2);
                    cap = 0;
                end
                if (iRST) begin
                    push_flags(B_LFALL, n + 1);
                    cap = 0;
                    rst_chk = 1'b1;
                end
                if (den && cap != 0)
                    push_ev(EV_STB, n + 2, h - HB, l - VB, pix(h - HB, l - VB));
            end
        end
    endtask

    initial begin
        iRST = 1'b1; iHD = 1'b1; iVD = 1'b1; iDEN = 1'b0;
        iLCD_R = 8'd0; iLCD_G = 8'd0; iLCD_B = 8'd0;
        repeat (3) @(negedge iCLK);
        chk_all_zero("reset");
        iRST = 1'b0;

        // nlines, long, short, rst, vd_ev, cap
        run_frame(TV, -1, -1, -1, 0,       0);  // f0  UNLOCK -> ACQUIRE
        run_frame(TV, -1, -1, -1, 0,       0);  // f1  good=1
        run_frame(TV, -1, -1, -1, B_LRISE, 1);  // f2  lock at 3rd VD fall
        run_frame(TV, -1, -1, -1, B_FS,    1);  // f3
        run_frame(TV,  1, -1, -1, B_FS,    1);  // f4  line 1 one clock long
        run_frame(TV, -1, -1, -1, 0,       0);  // f5  reacquire
        run_frame(TV, -1, -1, -1, 0,       0);  // f6
        run_frame(TV, -1, -1, -1, B_LRISE, 1);  // f7  relocked
        run_frame(TV, -1,  4, -1, B_FS,    1);  // f8  row 1 DEN one short
        run_frame(TV, -1, -1, -1, 0,       0);  // f9
        run_frame(TV - 1, -1, -1, -1, 0,   0);  // f10 one line short, in ACQUIRE
        run_frame(TV, -1, -1, -1, B_ERR,   0);  // f11 frame error -> UNLOCK
        run_frame(TV, -1, -1, -1, 0,       0);  // f12
        run_frame(TV, -1, -1, -1, 0,       0);  // f13
        run_frame(TV, -1, -1, -1, B_LRISE, 1);  // f14
        run_frame(TV, -1, -1,  1, B_FS,    1);  // f15 reset while locked
        run_frame(TV, -1, -1, -1, 0,       0);  // f16
        run_frame(TV, -1, -1, -1, 0,       0);  // f17
        run_frame(TV, -1, -1, -1, B_LRISE, 1);  // f18
        run_frame(TV, -1, -1, -1, B_FS,    1);  // f19

        @(negedge iCLK);
        iHD = 1'b1; iVD = 1'b1; iDEN = 1'b0;
        repeat (10) @(negedge iCLK);

        chk("leftover_expected", exp_q.size(), 0);
        // 6 full frames of 72 pixels, plus 12 + 11 before the short-DEN error
        chk("strobe_total", strobes, 455);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
